// File: rtl/ext_int_ctrl.sv
// ext_int_ctrl: per-source synchronising gateways, fixed-priority arbiter and a
// claim/complete register port driving one machine-external interrupt request.
//
// state | meaning
// IDLE  | nothing enabled and pending; meip_o low
// REQ   | request raised to the core, waiting for a claim read
// SERV  | srv_id claimed and in service; waiting for its COMPLETE
module ext_int_ctrl #(
  parameter int N_SRC       = 3,
  parameter int SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [N_SRC-1:0] int_in,
  input  logic             reg_we,
  input  logic             reg_re,
  input  logic [3:0]       reg_addr,
  input  logic [31:0]      reg_wdata,
  output logic [31:0]      reg_rdata,
  output logic             meip_o
);

  typedef enum logic [1:0] {IDLE, REQ, SERV} state_t;

  localparam logic [1:0] A_ENABLE = 2'd0;
  localparam logic [1:0] A_EDGE   = 2'd1;
  localparam logic [1:0] A_PEND   = 2'd2;
  localparam logic [1:0] A_CLAIM  = 2'd3;

  state_t           state_q, state_d;
  logic [N_SRC-1:0] sync_q [SYNC_STAGES];
  logic [N_SRC-1:0] s_prev_q;
  logic [N_SRC-1:0] enable_q, enable_d;
  logic [N_SRC-1:0] edge_q, edge_d;
  logic [N_SRC-1:0] pending_q, pending_d;
  logic [4:0]       srv_id_q, srv_id_d;
  logic [31:0]      rdata_q, rdata_d;
  logic             meip_q, meip_d;

  logic [N_SRC-1:0] s, pe;
  logic [4:0]       win_id;
  logic             any_pe, rd_only, claim_rd, claim_fire, complete;
  logic             unused_bits;

  assign s           = sync_q[SYNC_STAGES-1];
  assign pe          = pending_q & enable_q;
  assign any_pe      = |pe;
  assign rd_only     = reg_re & ~reg_we;
  assign claim_rd    = rd_only && (reg_addr[3:2] == A_CLAIM);
  assign claim_fire  = claim_rd && (state_q == REQ) && any_pe;
  assign complete    = reg_we && (reg_addr[3:2] == A_CLAIM) && (state_q == SERV)
                       && (reg_wdata[4:0] == srv_id_q);
  assign unused_bits = ^{reg_addr[1:0], reg_wdata};

  assign reg_rdata = rdata_q;
  assign meip_o    = meip_q;

  // Scan from the top so the lowest pending index wins.
  always_comb begin
    win_id = '0;
    for (int i = N_SRC - 1; i >= 0; i--) begin
      if (pe[i]) win_id = 5'(i + 1);
    end
  end

  // Gateway stays closed for the source in service, including its claim cycle.
  always_comb begin
    pending_d = pending_q;
    for (int i = 0; i < N_SRC; i++) begin
      if (claim_fire && (win_id == 5'(i + 1))) begin
        pending_d[i] = 1'b0;
      end else if (!((state_q == SERV) && (srv_id_q == 5'(i + 1)))) begin
        if (edge_q[i] ? (s[i] & ~s_prev_q[i]) : s[i]) pending_d[i] = 1'b1;
      end
    end
  end

  always_comb begin
    enable_d = enable_q;
    edge_d   = edge_q;
    if (reg_we && (reg_addr[3:2] == A_ENABLE)) enable_d = reg_wdata[N_SRC-1:0];
    if (reg_we && (reg_addr[3:2] == A_EDGE))   edge_d   = reg_wdata[N_SRC-1:0];

    rdata_d = '0;
    if (rd_only) begin
      case (reg_addr[3:2])
        A_ENABLE: rdata_d = 32'(enable_q);
        A_EDGE:   rdata_d = 32'(edge_q);
        A_PEND:   rdata_d = 32'(pending_q);
        default:  rdata_d = claim_fire ? 32'(win_id) : '0;
      endcase
    end
  end

  always_comb begin
    state_d  = state_q;
    srv_id_d = srv_id_q;
    case (state_q)
      IDLE: if (any_pe) state_d = REQ;
      REQ: begin
        if (!any_pe) begin
          state_d = IDLE;
        end else if (claim_rd) begin
          state_d  = SERV;
          srv_id_d = win_id;
        end
      end
      SERV:    if (complete) state_d = IDLE;
      default: state_d = IDLE;
    endcase
    // Registered request: high only while staying in REQ, so it drops with the claim.
    meip_d = (state_q == REQ) && (state_d == REQ);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < SYNC_STAGES; k++) sync_q[k] <= '0;
      s_prev_q  <= '0;
      enable_q  <= '0;
      edge_q    <= '0;
      pending_q <= '0;
      srv_id_q  <= '0;
      rdata_q   <= '0;
      meip_q    <= 1'b0;
      state_q   <= IDLE;
    end else begin
      sync_q[0] <= int_in;
      for (int k = 1; k < SYNC_STAGES; k++) sync_q[k] <= sync_q[k-1];
      s_prev_q  <= s;
      enable_q  <= enable_d;
      edge_q    <= edge_d;
      pending_q <= pending_d;
      srv_id_q  <= srv_id_d;
      rdata_q   <= rdata_d;
      meip_q    <= meip_d;
      state_q   <= state_d;
    end
  end

endmodule

// File: tb/tb_ext_int_ctrl.sv
// Bench for ext_int_ctrl: a set-level reference model predicts read data into a
// queue that a monitor drains one clock after every read strobe.
module tb_ext_int_ctrl;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [2:0]  int_in = 3'b111;
  logic        reg_we = 1'b0;
  logic        reg_re = 1'b0;
  logic [3:0]  reg_addr = 4'h0;
  logic [31:0] reg_wdata = 32'h0;
  logic [31:0] reg_rdata;
  logic        meip_o;

  int errors = 0;
  int checks = 0;
  logic [31:0] exp_q[$];

  // Model: enable/edge registers, pending set, id in service (0 = none), line levels.
  logic [2:0] line = 3'b111;
  logic [2:0] m_en = 3'b000;
  logic [2:0] m_edge = 3'b000;
  logic [2:0] m_pend = 3'b000;
  int         m_srv = 0;

  ext_int_ctrl #(.N_SRC(3), .SYNC_STAGES(2)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .int_in    (int_in),
    .reg_we    (reg_we),
    .reg_re    (reg_re),
    .reg_addr  (reg_addr),
    .reg_wdata (reg_wdata),
    .reg_rdata (reg_rdata),
    .meip_o    (meip_o)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  initial begin : monitor
    logic seen;
    forever begin
      @(posedge clk);
      seen = reg_re;
      @(negedge clk);
      if (seen) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL rdata: got %0h with no expected read queued", reg_rdata);
        end else begin
          check("rdata", reg_rdata, exp_q.pop_front());
        end
      end
    end
  end

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  function automatic logic [2:0] svc_mask();
    return (m_srv == 0) ? 3'b000 : 3'(1 << (m_srv - 1));
  endfunction

  function automatic int lowest(input logic [2:0] v);
    for (int i = 0; i < 3; i++) if (v[i]) return i + 1;
    return 0;
  endfunction

  task automatic settle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic set_lines(input logic [2:0] v);
    m_pend |= ((v & ~line & m_edge) | (v & ~m_edge)) & ~svc_mask();
    line   = v;
    int_in = v;
    @(negedge clk);
  endtask

  task automatic pulse(input logic [2:0] v);
    logic [2:0] old;
    old = line;
    set_lines(old | v);
    set_lines(old);
  endtask

  task automatic wr(input logic [3:0] a, input logic [31:0] d);
    case (a[3:2])
      2'd0: m_en = d[2:0];
      2'd1: begin
        m_edge = d[2:0];
        m_pend |= ~m_edge & line & ~svc_mask();
      end
      2'd3: if (m_srv != 0 && d[4:0] == 5'(m_srv)) begin
        m_srv = 0;
        m_pend |= ~m_edge & line;
      end
      default: ;
    endcase
    reg_we = 1'b1; reg_addr = a; reg_wdata = d;
    @(negedge clk);
    reg_we = 1'b0; reg_wdata = 32'h0;
  endtask

  task automatic rd(input logic [3:0] a);
    logic [31:0] e;
    case (a[3:2])
      2'd0: e = 32'(m_en);
      2'd1: e = 32'(m_edge);
      2'd2: e = 32'(m_pend);
      default: begin
        e = 32'h0;
        if (m_srv == 0 && (m_pend & m_en) != 3'b000) begin
          m_srv  = lowest(m_pend & m_en);
          e      = 32'(m_srv);
          m_pend &= ~svc_mask();
        end
      end
    endcase
    exp_q.push_back(e);
    reg_re = 1'b1; reg_addr = a;
    @(negedge clk);
    reg_re = 1'b0;
    if (a[3:2] == 2'd3) check("meip_after_claim", {31'b0, meip_o}, 32'h0);
  endtask

  task automatic chk_meip(input string n);
    logic e;
    e = (m_srv == 0) && ((m_pend & m_en) != 3'b000);
    check(n, {31'b0, meip_o}, {31'b0, e});
  endtask

  task automatic drain();
    repeat (4) begin
      settle(6);
      if (m_srv == 0 && (m_pend & m_en) != 3'b000) begin
        rd(4'hC);
        settle(2);
        wr(4'hC, 32'(m_srv));
      end
    end
    settle(6);
  endtask

  initial begin : stim
    int op;
    // Reset with all lines high and nothing enabled.
    settle(3);
    check("reset_meip", {31'b0, meip_o}, 32'h0);
    check("reset_rdata", reg_rdata, 32'h0);
    rst_n = 1'b1;
    for (int k = 1; k <= 3; k++) begin
      @(negedge clk);
      check("reset_meip_disabled", {31'b0, meip_o}, 32'h0);
    end
    m_pend = line & ~m_edge;
    rd(4'h8);
    set_lines(3'b000);
    wr(4'h0, 32'h7);
    drain();
    chk_meip("meip_after_drain");

    // Level rise to request latency.
    line = 3'b001; int_in = 3'b001; m_pend |= 3'b001;
    for (int k = 1; k <= 5; k++) begin
      @(negedge clk);
      check("meip_latency", {31'b0, meip_o}, (k >= 5) ? 32'h1 : 32'h0);
    end
    rd(4'hC);
    wr(4'hC, 32'h3);
    settle(2);
    chk_meip("meip_wrong_complete");
    rd(4'hC);
    wr(4'hC, 32'h1);
    settle(6);
    chk_meip("meip_level_repend");
    rd(4'hC);
    set_lines(3'b000);
    settle(3);
    wr(4'hC, 32'h1);
    settle(6);
    chk_meip("meip_no_repend");
    rd(4'h8);

    // COMPLETE with another source pending: request three clocks later.
    set_lines(3'b001);
    settle(6);
    rd(4'hC);
    set_lines(3'b011);
    settle(6);
    chk_meip("meip_in_serv");
    set_lines(3'b010);
    settle(4);
    wr(4'hC, 32'h1);
    check("complete_t1", {31'b0, meip_o}, 32'h0);
    @(negedge clk);
    check("complete_t2", {31'b0, meip_o}, 32'h0);
    @(negedge clk);
    check("complete_t3", {31'b0, meip_o}, 32'h1);

    // Disable while requesting, then re-enable.
    wr(4'h0, 32'h0);
    check("disable_t1", {31'b0, meip_o}, 32'h1);
    @(negedge clk);
    check("disable_t2", {31'b0, meip_o}, 32'h0);
    rd(4'hC);
    wr(4'h0, 32'h7);
    settle(4);
    chk_meip("meip_reenable");
    rd(4'hC);
    set_lines(3'b000);
    settle(3);
    wr(4'hC, 32'h2);
    settle(6);
    chk_meip("meip_idle");

    // Edge sources pulsed together.
    wr(4'h4, 32'h7);
    pulse(3'b110);
    settle(6);
    chk_meip("meip_edge_pulse");
    rd(4'hC);
    rd(4'h8);
    wr(4'hC, 32'h2);
    settle(6);
    rd(4'hC);
    settle(2);
    wr(4'hC, 32'h3);
    settle(6);

    // Simultaneous write and read: write lands, read returns 0.
    m_en = 3'b101;
    exp_q.push_back(32'h0);
    reg_we = 1'b1; reg_re = 1'b1; reg_addr = 4'h0; reg_wdata = 32'h5;
    @(negedge clk);
    reg_we = 1'b0; reg_re = 1'b0; reg_wdata = 32'h0;
    rd(4'h0);
    rd(4'h4);
    wr(4'h0, 32'h7);

    // Randomised operations against the model.
    for (int it = 0; it < 40; it++) begin
      op = int'($urandom_range(0, 5));
      case (op)
        0: wr(4'h0, 32'($urandom_range(0, 7)));
        1: wr(4'h4, 32'($urandom_range(0, 7)));
        2: pulse(3'($urandom_range(1, 7)));
        3: set_lines(3'($urandom_range(0, 7)));
        4: rd(4'hC);
        default: wr(4'hC, ((m_srv != 0) && ($urandom_range(0, 1) == 1))
                          ? 32'(m_srv) : 32'($urandom_range(0, 3)));
      endcase
      settle(6);
      chk_meip("meip_random");
      rd(4'h8);
    end
    set_lines(3'b000);
    settle(6);
    if (m_srv != 0) wr(4'hC, 32'(m_srv));
    wr(4'h0, 32'h7);
    drain();

    // Edge on the source in service is dropped.
    wr(4'h4, 32'h7);
    pulse(3'b001);
    settle(6);
    rd(4'hC);
    settle(2);
    pulse(3'b001);
    settle(6);
    wr(4'hC, 32'h1);
    settle(6);
    rd(4'h8);
    chk_meip("meip_after_drop");

    // Reset in the middle of a service.
    pulse(3'b001);
    settle(6);
    rd(4'hC);
    rst_n = 1'b0;
    #1;
    check("midreset_meip", {31'b0, meip_o}, 32'h0);
    check("midreset_rdata", reg_rdata, 32'h0);
    m_en = 3'b000; m_edge = 3'b000; m_pend = 3'b000; m_srv = 0;
    settle(2);
    rst_n = 1'b1;
    settle(4);
    rd(4'h0);
    rd(4'h4);
    rd(4'h8);
    rd(4'hC);
    chk_meip("meip_after_reset");

    settle(2);
    check("scoreboard_drained", 32'(exp_q.size()), 32'h0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
